prio_encoder_seq: RTL and testbench
===================================

PRIO_ENCODER_SEQ -- requirements
Module: prio_encoder_seq

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset; 0 forces reset state immediately.
REQ-004 Ports Y0, Y1, Y2, Y3, input, 1 each: request lines, sampled every rising edge; Y3 has the highest priority.
REQ-005 Port EN, input, 1: grant enable; 1 allows a new grant to be issued.
REQ-006 Port ACK, input, 1: consumer acknowledge of the current grant.
REQ-007 Ports A0, A1, output, 1 each: registered encoded index of the granted request (A1 is the MSB).
REQ-008 Port V, output, 1: registered grant-valid flag.
REQ-009 Port PEND, output, 4: registered pending-request vector; bit i corresponds to Yi.
REQ-010 Port OVF, output, 1: sticky overflow flag.

Function
REQ-011 Each request edge SHALL set its pend bit: if Yi=1 at an edge, PEND[i]=1 after that edge.
REQ-012 The block SHALL have two states, IDLE and HOLD.
REQ-013 In IDLE with EN=1 and PEND!=0 at an edge, the block SHALL:
- load A1:A0 with the index of the highest set PEND bit (3 > 2 > 1 > 0);
- set V=1;
- enter HOLD.
REQ-014 Grant selection SHALL use the registered PEND value, not same-cycle Y inputs, so Yi high at edge n gives earliest V=1 after edge n+1.
REQ-015 In IDLE with EN=0 or PEND=0, the block SHALL keep V=0 and remain in IDLE; requests are still captured.
REQ-016 In HOLD, A1:A0 and V=1 SHALL stay stable until ACK=1 is sampled; EN is ignored.
REQ-017 When ACK=1 is sampled in HOLD, the block SHALL clear PEND[A1:A0], set V=0 and enter IDLE.
REQ-018 If Yi=1 for the granted index in the same cycle as ACK, set SHALL win and PEND[i] SHALL remain 1.
REQ-019 ACK sampled in IDLE SHALL be ignored.
REQ-020 After each ACK there SHALL be at least one IDLE cycle with V=0, so the maximum rate is one grant per two cycles.
REQ-021 When V=0, A1:A0 SHALL hold the last granted index.
REQ-022 OVF SHALL be set when Yi=1 is sampled while PEND[i]=1 and PEND[i] is not being cleared in that cycle.
REQ-023 OVF SHALL stay 1 until reset.
REQ-024 Lower-priority pending bits SHALL be preserved across any number of grants; no request is lost except via overflow.

Reset
REQ-025 While rst_n=0, the outputs SHALL be A1:A0=00, V=0, PEND=0000, OVF=0, with state IDLE, independent of clk.
REQ-026 A reset asserted during HOLD SHALL abort the grant immediately, with all pending requests discarded.
REQ-027 After rst_n deasserts, the first edge SHALL capture Y inputs normally.

Verification
REQ-028 Reset with Y=0000 and EN=0 SHALL give A=00, V=0, PEND=0000, OVF=0; these values SHALL hold with rst_n=0 and clocks running.
REQ-029 Y1 pulsed for one cycle with EN=1 and ACK=0 SHALL give PEND=0010 next cycle, then V=1 with A1:A0=01, held until ACK=1; after ACK, V=0 and PEND=0000.
REQ-030 Y0, Y2 and Y3 pulsed together with EN=1 and ACK returned one cycle after each V SHALL give grants A=11, then 10, then 00, each separated by a V=0 cycle, ending with PEND=0000.
REQ-031 Y2 pulsed with EN=0 for 5 cycles SHALL keep V=0 and PEND=0100; raising EN SHALL give V=1 and A=10 one edge later.
REQ-032 Y3 pulsed twice while PEND[3]=1 and ungranted SHALL give OVF=1, which SHALL stay 1 through subsequent grants; Y3 high in the ACK cycle of a Y3 grant SHALL leave PEND[3]=1 and OVF=0.
REQ-033 rst_n driven low mid-HOLD with A=10 and V=1 SHALL immediately give V=0, A=00 and PEND=0000 without waiting for a clock edge.

Source files
------------

// File: rtl/prio_encoder_seq.sv
// Sequential 4-input priority encoder with pending capture and ACK handshake.
// Ports: clk, rst_n, Y0-Y3 requests, EN, ACK in; A1:A0, V, PEND[3:0], OVF out.
module prio_encoder_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Y0,
  input  logic       Y1,
  input  logic       Y2,
  input  logic       Y3,
  input  logic       EN,
  input  logic       ACK,
  output logic       A0,
  output logic       A1,
  output logic       V,
  output logic [3:0] PEND,
  output logic       OVF
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] a_q, a_d;
  logic [3:0] pend_q, pend_d;
  logic       ovf_q, ovf_d;
  logic [3:0] y;
  logic [3:0] clr;
  logic [1:0] enc;

  assign y = {Y3, Y2, Y1, Y0};

  // Highest set pend bit wins; grants come from registered state only.
  always_comb begin
    enc = 2'd0;
    if (pend_q[3])      enc = 2'd3;
    else if (pend_q[2]) enc = 2'd2;
    else if (pend_q[1]) enc = 2'd1;
    else                enc = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    clr     = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (EN && (pend_q != 4'b0000)) begin
          state_d = HOLD;
          a_d     = enc;
        end
      end
      HOLD: begin
        if (ACK) begin
          state_d = IDLE;
          clr     = 4'b0001 << a_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // New request wins over the clear of the same bit.
    pend_d = (pend_q & ~clr) | y;
    ovf_d  = ovf_q | (|(y & pend_q & ~clr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 2'd0;
      pend_q  <= 4'b0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign A0   = a_q[0];
  assign A1   = a_q[1];
  assign V    = (state_q == HOLD);
  assign PEND = pend_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Directed bench for prio_encoder_seq.
// obs packs {A1,A0,V,PEND[3:0],OVF}.
module tb_prio_encoder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Y0 = 1'b0, Y1 = 1'b0, Y2 = 1'b0, Y3 = 1'b0;
  logic       EN = 1'b0, ACK = 1'b0;
  logic       A0, A1, V, OVF;
  logic [3:0] PEND;
  logic [7:0] obs;
  int         checks = 0;
  int         failures = 0;

  prio_encoder_seq dut (
    .clk(clk), .rst_n(rst_n),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .EN(EN), .ACK(ACK),
    .A0(A0), .A1(A1), .V(V),
    .PEND(PEND), .OVF(OVF)
  );

  always #5 clk = ~clk;

  assign obs = {A1, A0, V, PEND, OVF};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_y(input logic [3:0] v);
    {Y3, Y2, Y1, Y0} = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_y(4'b0000);
    EN = 1'b0;
    ACK = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_y(4'b0000);
    EN = 1'b0;
    ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== 8'b00_0_0000_0) begin
        failures++;
        $display("FAIL reset[%0d] got=%b want=%b", i, obs, 8'b00_0_0000_0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    EN = 1'b1;
    set_y(4'b0010);
    step();
    checks++;
    if (obs !== 8'b00_0_0010_0) begin
      failures++;
      $display("FAIL single_capture got=%b want=%b", obs, 8'b00_0_0010_0);
    end
    set_y(4'b0000);
    step();
    checks++;
    if (obs !== 8'b01_1_0010_0) begin
      failures++;
      $display("FAIL single_grant got=%b want=%b", obs, 8'b01_1_0010_0);
    end
    EN = 1'b0;
    step();
    step();
    checks++;
    if (obs !== 8'b01_1_0010_0) begin
      failures++;
      $display("FAIL single_hold got=%b want=%b", obs, 8'b01_1_0010_0);
    end
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    checks++;
    if (obs !== 8'b01_0_0000_0) begin
      failures++;
      $display("FAIL single_ack got=%b want=%b", obs, 8'b01_0_0000_0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_g [3];
    logic [7:0] exp_a [3];
    exp_g[0] = 8'b11_1_1101_0;
    exp_a[0] = 8'b11_0_0101_0;
    exp_g[1] = 8'b10_1_0101_0;
    exp_a[1] = 8'b10_0_0001_0;
    exp_g[2] = 8'b00_1_0001_0;
    exp_a[2] = 8'b00_0_0000_0;
    do_reset();
    EN = 1'b1;
    set_y(4'b1101);
    step();
    set_y(4'b0000);
    checks++;
    if (obs !== 8'b00_0_1101_0) begin
      failures++;
      $display("FAIL b2b_capture got=%b want=%b", obs, 8'b00_0_1101_0);
    end
    for (int g = 0; g < 3; g++) begin
      step();
      checks++;
      if (obs !== exp_g[g]) begin
        failures++;
        $display("FAIL b2b_grant[%0d] got=%b want=%b", g, obs, exp_g[g]);
      end
      ACK = 1'b1;
      step();
      ACK = 1'b0;
      checks++;
      if (obs !== exp_a[g]) begin
        failures++;
        $display("FAIL b2b_ack[%0d] got=%b want=%b", g, obs, exp_a[g]);
      end
    end
  endtask

  task automatic test_enable_and_reset_abort();
    do_reset();
    EN = 1'b0;
    set_y(4'b0100);
    step();
    set_y(4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== 8'b00_0_0100_0) begin
        failures++;
        $display("FAIL en_low[%0d] got=%b want=%b", i, obs, 8'b00_0_0100_0);
      end
    end
    EN = 1'b1;
    step();
    checks++;
    if (obs !== 8'b10_1_0100_0) begin
      failures++;
      $display("FAIL en_grant got=%b want=%b", obs, 8'b10_1_0100_0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'b00_0_0000_0) begin
      failures++;
      $display("FAIL async_abort got=%b want=%b", obs, 8'b00_0_0000_0);
    end
    step();
    rst_n = 1'b1;
    EN = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    EN = 1'b0;
    set_y(4'b1000);
    step();
    checks++;
    if (obs !== 8'b00_0_1000_0) begin
      failures++;
      $display("FAIL ovf_first got=%b want=%b", obs, 8'b00_0_1000_0);
    end
    step();
    set_y(4'b0000);
    checks++;
    if (obs !== 8'b00_0_1000_1) begin
      failures++;
      $display("FAIL ovf_set got=%b want=%b", obs, 8'b00_0_1000_1);
    end
    EN = 1'b1;
    step();
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    checks++;
    if (obs !== 8'b11_0_0000_1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b want=%b", obs, 8'b11_0_0000_1);
    end
    do_reset();
    EN = 1'b1;
    set_y(4'b1000);
    step();
    set_y(4'b0000);
    step();
    checks++;
    if (obs !== 8'b11_1_1000_0) begin
      failures++;
      $display("FAIL setwin_grant got=%b want=%b", obs, 8'b11_1_1000_0);
    end
    set_y(4'b1000);
    ACK = 1'b1;
    step();
    set_y(4'b0000);
    ACK = 1'b0;
    checks++;
    if (obs !== 8'b11_0_1000_0) begin
      failures++;
      $display("FAIL setwin_ack got=%b want=%b", obs, 8'b11_0_1000_0);
    end
  endtask

  task automatic test_ack_idle_and_en_hold();
    do_reset();
    EN = 1'b0;
    set_y(4'b0010);
    step();
    set_y(4'b0000);
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    checks++;
    if (obs !== 8'b00_0_0010_0) begin
      failures++;
      $display("FAIL ack_idle got=%b want=%b", obs, 8'b00_0_0010_0);
    end
    EN = 1'b1;
    step();
    set_y(4'b1000);
    EN = 1'b0;
    step();
    set_y(4'b0000);
    checks++;
    if (obs !== 8'b01_1_1010_0) begin
      failures++;
      $display("FAIL hold_stable got=%b want=%b", obs, 8'b01_1_1010_0);
    end
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    EN = 1'b1;
    step();
    checks++;
    if (obs !== 8'b11_1_1000_0) begin
      failures++;
      $display("FAIL next_grant got=%b want=%b", obs, 8'b11_1_1000_0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_and_reset_abort();
    test_overflow();
    test_ack_idle_and_en_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
